// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: width codes, FSM states, fault codes.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [1:0] FLT_NONE  = 2'b00;
    localparam logic [1:0] FLT_MIS   = 2'b01;
    localparam logic [1:0] FLT_RANGE = 2'b10;
    localparam logic [1:0] FLT_ILL   = 2'b11;

    // Access size in bytes from the low two bits of funct3.
    function automatic logic [2:0] f3_size(input logic [1:0] width_code);
        case (width_code)
            2'b00:   f3_size = 3'd1;
            2'b01:   f3_size = 3'd2;
            default: f3_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// Byte/halfword lane handling: load extraction with extension and store merge
// into a fetched word. Purely combinational, little-endian lanes.
module lsu_lane_unit
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_store_val,
    output logic [31:0] o_load_val,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_B:    o_load_val = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_val = {24'd0, w_byte};
            F3_H:    o_load_val = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_val = {16'd0, w_half};
            default: o_load_val = i_word;
        endcase

        o_merged = i_word;
        case (i_funct3)
            F3_B:    o_merged[{i_addr_lo, 3'b000} +: 8]   = i_store_val[7:0];
            F3_H:    o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_store_val[15:0];
            F3_W:    o_merged = i_store_val;
            default: o_merged = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit: byte/half/word access over a word-only memory,
// read-modify-write for sub-word stores, faulting of bad requests.
//
// state | meaning
// IDLE  | waiting for req; captures request and fault code
// RD    | memory word addressed; load result or merged store word taken at exit
// WR    | mem_write high for this single cycle
// DONE  | done pulse, fault presented
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  fault,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

    lsu_state_e  r_state;
    logic        r_is_store;
    logic [2:0]  r_funct3;
    logic [1:0]  r_addr_lo;
    logic [31:0] r_store_data;
    logic        r_busy;
    logic        r_done;
    logic        r_mem_write;
    logic [31:0] r_load_data;
    logic [1:0]  r_fault;
    logic [31:0] r_mem_adr;
    logic [31:0] r_mem_write_data;

    logic [2:0]  w_size;
    logic [32:0] w_end;
    logic        w_legal;
    logic        w_mis;
    logic [1:0]  w_fault;
    logic [31:0] w_load_val;
    logic [31:0] w_merged;

    always_comb begin
        w_size = f3_size(funct3[1:0]);
        w_end  = {1'b0, addr} + {30'd0, w_size};
        case (funct3)
            F3_B, F3_H, F3_W: w_legal = 1'b1;
            F3_BU, F3_HU:     w_legal = !is_store;
            default:          w_legal = 1'b0;
        endcase
        w_mis = ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) ||
                (funct3 == F3_W && addr[1:0] != 2'b00);
        if (!w_legal)
            w_fault = FLT_ILL;
        else if (w_mis)
            w_fault = FLT_MIS;
        else if (w_end > MEM_LIMIT)
            w_fault = FLT_RANGE;
        else
            w_fault = FLT_NONE;
    end

    lsu_lane_unit u_lane (
        .i_word      (mem_read_data),
        .i_addr_lo   (r_addr_lo),
        .i_funct3    (r_funct3),
        .i_store_val (r_store_data),
        .o_load_val  (w_load_val),
        .o_merged    (w_merged)
    );

    // The merged store word is registered straight into mem_write_data at the
    // end of RD, so it doubles as the read buffer for the write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_is_store       <= 1'b0;
            r_funct3         <= 3'd0;
            r_addr_lo        <= 2'd0;
            r_store_data     <= 32'd0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_mem_write      <= 1'b0;
            r_load_data      <= 32'd0;
            r_fault          <= FLT_NONE;
            r_mem_adr        <= 32'd0;
            r_mem_write_data <= 32'd0;
        end else begin
            r_done      <= 1'b0;
            r_mem_write <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_is_store   <= is_store;
                        r_funct3     <= funct3;
                        r_addr_lo    <= addr[1:0];
                        r_store_data <= store_data;
                        r_mem_adr    <= {addr[31:2], 2'b00};
                        r_fault      <= w_fault;
                        r_busy       <= 1'b1;
                        if (w_fault != FLT_NONE) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (is_store && funct3 == F3_W) begin
                            r_state          <= ST_WR;
                            r_mem_write      <= 1'b1;
                            r_mem_write_data <= store_data;
                        end else begin
                            r_state <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (r_is_store) begin
                        r_state          <= ST_WR;
                        r_mem_write      <= 1'b1;
                        r_mem_write_data <= w_merged;
                    end else begin
                        r_state     <= ST_DONE;
                        r_done      <= 1'b1;
                        r_load_data <= w_load_val;
                    end
                end
                ST_WR: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign load_data      = r_load_data;
    assign fault          = r_fault;
    assign mem_adr        = r_mem_adr;
    assign mem_write_data = r_mem_write_data;
    assign mem_write      = r_mem_write;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random ops against a byte-level
// reference memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic [31:0] load_data;
    logic [1:0]  fault;
    logic [31:0] mem_adr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic [31:0] mem_read_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [16384];
    logic [7:0]  ref_bytes [65536];
    logic [31:0] exp_load = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_BYTES(65536)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .is_store       (is_store),
        .funct3         (funct3),
        .addr           (addr),
        .store_data     (store_data),
        .busy           (busy),
        .done           (done),
        .load_data      (load_data),
        .fault          (fault),
        .mem_adr        (mem_adr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    assign mem_read_data = mem[mem_adr[15:2]];
    always @(posedge clk) if (mem_write) mem[mem_adr[15:2]] <= mem_write_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        mem[a[15:2]] = v;
        for (int i = 0; i < 4; i++) ref_bytes[{a[15:2], 2'b00} + i] = v[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_bytes[{a[15:2], 2'b00} + i];
        return w;
    endfunction

    // Reference: derive fault, latency, write count; apply effect to ref memory.
    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output logic [1:0] flt, output int lat,
                         output int nwr);
        int  size;
        bit  legal;
        logic [31:0] v;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
                && !(st && f3[2]);
        if (!legal)                                   flt = 2'b11;
        else if (a % size != 0)                       flt = 2'b01;
        else if (longint'(a) + size > 64'd65536)      flt = 2'b10;
        else                                          flt = 2'b00;
        nwr = 0;
        if (flt != 2'b00) lat = 1;
        else if (st) begin
            lat = (size == 4) ? 2 : 3;
            nwr = 1;
            for (int i = 0; i < size; i++) ref_bytes[int'(a) + i] = d[8*i +: 8];
        end else begin
            lat = 2;
            v = 32'd0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = ref_bytes[int'(a) + i];
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
            exp_load = v;
        end
    endtask

    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d);
        logic [1:0] e_flt;
        int e_lat, e_nwr;
        int done_cyc, wr_cyc, wr_cnt, cyc;
        model(st, f3, a, d, e_flt, e_lat, e_nwr);
        done_cyc = -1; wr_cyc = -1; wr_cnt = 0;
        @(negedge clk);
        req = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = d;
        @(negedge clk);
        req = 1'b0; is_store = $urandom_range(0, 1); addr = $urandom;
        check("busy_c1", {31'd0, busy}, 32'd1);
        for (cyc = 1; cyc < 10; cyc++) begin
            if (mem_write) begin wr_cnt++; wr_cyc = cyc; end
            if (done) begin done_cyc = cyc; break; end
            @(negedge clk);
        end
        check("done_lat", done_cyc, e_lat);
        check("fault", {30'd0, fault}, {30'd0, e_flt});
        check("wr_cnt", wr_cnt, e_nwr);
        if (e_nwr != 0) check("wr_cyc", wr_cyc, e_lat - 1);
        check("load_data", load_data, exp_load);
        if (e_flt == 2'b00) check("mem_word", mem[a[15:2]], ref_word(a));
    endtask

    initial begin
        logic [31:0] w_before;
        int ndone;
        rst = 1'b1; req = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        for (int i = 0; i < 16384; i++) set_word(i * 4, $urandom);
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_load_data", load_data, 32'd0);
        check("rst_fault", {30'd0, fault}, 32'd0);
        check("rst_mem_adr", mem_adr, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        @(negedge clk); rst = 1'b0;

        set_word(32'h100, 32'h8899AABB);
        run_op(1'b0, 3'b000, 32'h101, 32'h0); check("lb_const", load_data, 32'hFFFFFFAA);
        run_op(1'b0, 3'b100, 32'h101, 32'h0); check("lbu_const", load_data, 32'h000000AA);
        run_op(1'b0, 3'b001, 32'h102, 32'h0); check("lh_const", load_data, 32'hFFFF8899);
        run_op(1'b0, 3'b101, 32'h102, 32'h0); check("lhu_const", load_data, 32'h00008899);
        run_op(1'b0, 3'b010, 32'h100, 32'h0); check("lw_const", load_data, 32'h8899AABB);
        run_op(1'b1, 3'b000, 32'h102, 32'h12345677); check("sb_const", mem[32'h100 >> 2], 32'h8877AABB);
        set_word(32'h100, 32'h8899AABB);
        run_op(1'b1, 3'b001, 32'h100, 32'h0000CAFE); check("sh_const", mem[32'h100 >> 2], 32'h8899CAFE);
        run_op(1'b1, 3'b010, 32'h104, 32'hDEADBEEF); check("sw_const", mem[32'h104 >> 2], 32'hDEADBEEF);
        run_op(1'b0, 3'b010, 32'h102, 32'h0);    check("f_lw_mis", {30'd0, fault}, 32'd1);
        run_op(1'b0, 3'b001, 32'hFFFF, 32'h0);   check("f_lh_mis", {30'd0, fault}, 32'd1);
        run_op(1'b0, 3'b000, 32'h10000, 32'h0);  check("f_lb_rng", {30'd0, fault}, 32'd2);
        run_op(1'b1, 3'b010, 32'hFFFC, 32'h01020304); check("sw_top", {30'd0, fault}, 32'd0);
        run_op(1'b0, 3'b011, 32'h100, 32'h0);    check("f_ill", {30'd0, fault}, 32'd3);
        run_op(1'b1, 3'b100, 32'h100, 32'h0);    check("f_st_bu", {30'd0, fault}, 32'd3);

        // Reset while an SB sits in RD: no write may ever reach memory.
        w_before = mem[32'h100 >> 2];
        @(negedge clk);
        req = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h101; store_data = 32'h55;
        @(negedge clk);
        req = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_wr", {31'd0, mem_write}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_word", mem[32'h100 >> 2], w_before);
        exp_load = 32'd0;

        // req held through busy and DONE must produce exactly one completion.
        ndone = 0;
        @(negedge clk);
        req = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("one_done", ndone, 1);
        exp_load = ref_word(32'h100);
        check("busy_ld", load_data, exp_load);

        for (int n = 0; n < 150; n++) begin
            int r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if (r < 7)      a = 32'h100 + $urandom_range(0, 63);
            else if (r < 9) a = 32'hFFF8 + $urandom_range(0, 15);
            else            a = $urandom;
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
